// File: rtl/axi_ctrl_master.sv
// axi_ctrl_master
// Turns single control-register commands into AXI-lite read or write
// transactions, with one transaction in flight at a time. It returns one
// response per command. If an AXI phase is not completed within TIMEOUT
// cycles, the transaction is abandoned.
//
// Ports:
//   clk, reset                     clock, async active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write/addr/wdata/wstrb     command payload (write=1, read=0)
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_resp/rsp_timeout response payload
//   ar*, r*                        AXI-lite read channels (master side)
//   aw*, w*, b*                    AXI-lite write channels (master side)
//   busy                           high whenever the FSM is not in IDLE
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// WR_REQ  | AW and W offered, each dropped independently once accepted
// WR_RESP | bready high, waiting for the write response
// RD_REQ  | arvalid high, waiting for arready
// RD_DATA | rready high, waiting for read data
// RSP     | rsp_valid high with a stable payload until rsp_ready
module axi_ctrl_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  input  logic [1:0]          bresp,
  output logic                bready,
  output logic                busy
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t      state;
  logic [15:0] phase_cnt;
  logic        aw_done, w_done;
  logic        aw_ok, w_ok, in_phase, phase_done, timeout_now;

  // aw_done/w_done remember a handshake from an earlier cycle. This lets the
  // two write channels be accepted in any order.
  assign aw_ok = aw_done | (awvalid & awready);
  assign w_ok  = w_done  | (wvalid & wready);

  assign in_phase = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_DATA);

  assign phase_done = ((state == WR_REQ)  && aw_ok && w_ok)        ||
                      ((state == WR_RESP) && bvalid && bready)     ||
                      ((state == RD_REQ)  && arvalid && arready)   ||
                      ((state == RD_DATA) && rvalid && rready);

  // A handshake on the last allowed cycle wins over the timeout.
  assign timeout_now = in_phase && !phase_done && (phase_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
      araddr      <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      awaddr      <= '0;
      awvalid     <= 1'b0;
      wdata       <= '0;
      wstrb       <= '0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
    end else if (timeout_now) begin
      state       <= RSP;
      phase_cnt   <= '0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      arvalid     <= 1'b0;
      bready      <= 1'b0;
      rready      <= 1'b0;
      rsp_valid   <= 1'b1;
      rsp_timeout <= 1'b1;
      rsp_resp    <= 2'b10;
      rsp_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            rsp_timeout <= 1'b0;
            phase_cnt   <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            if (cmd_write) begin
              state   <= WR_REQ;
              awaddr  <= cmd_addr;
              wdata   <= cmd_wdata;
              wstrb   <= cmd_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= RD_REQ;
              araddr  <= cmd_addr;
              arvalid <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          aw_done <= aw_ok;
          w_done  <= w_ok;
          if (aw_ok && w_ok) begin
            state     <= WR_RESP;
            bready    <= 1'b1;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        WR_RESP: begin
          if (bvalid && bready) begin
            state     <= RSP;
            bready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= bresp;
            rsp_rdata <= '0;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        RD_REQ: begin
          if (arvalid && arready) begin
            state     <= RD_DATA;
            arvalid   <= 1'b0;
            rready    <= 1'b1;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        RD_DATA: begin
          if (rvalid && rready) begin
            state     <= RSP;
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata;
            rsp_resp  <= rresp;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ctrl_master.sv
// Directed bench for axi_ctrl_master (TIMEOUT=8). Inputs are driven and
// outputs sampled on the falling edge. Expected responses are queued when a
// command is issued and popped when rsp_valid appears.
module tb_axi_ctrl_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [11:0] araddr, awaddr;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] rdata, wdata;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, busy;
  logic [3:0]  wstrb;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   aw_hs = 0;
  int   w_hs  = 0;

  always #5 clk = ~clk;

  axi_ctrl_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready), .busy(busy)
  );

  always @(posedge clk) begin
    if (awvalid && awready) aw_hs++;
    if (wvalid && wready)   w_hs++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [31:0] d, input logic [1:0] r, input logic t);
    rsp_t e;
    e.rdata = d;
    e.resp  = r;
    e.to    = t;
    exp_q.push_back(e);
  endfunction

  task automatic send_cmd(input logic w, input logic [11:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready before issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy after accept", busy, 1);
    chk("cmd_ready after accept", cmd_ready, 0);
  endtask

  task automatic get_rsp(input int hold);
    int   n = 0;
    bit   bad = 0;
    rsp_t e;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid arrives", rsp_valid, 1);
    if (!rsp_valid) return;
    chk("scoreboard has entry", (exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_resp", rsp_resp, e.resp);
    chk("rsp_timeout", rsp_timeout, e.to);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== e.rdata || rsp_resp !== e.resp || cmd_ready !== 1'b0)
        bad = 1;
    end
    if (hold > 0) chk("rsp held stable, cmd_ready low", bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle cmd_ready", cmd_ready, 1);
    chk("idle busy", busy, 0);
    chk("rsp_valid dropped", rsp_valid, 0);
  endtask

  initial begin
    int hi;
    int aw0, w0;
    int seen;
    reset = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0; arready = 0; rdata = '0; rresp = '0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0;
    #1;
    chk("reset cmd_ready", cmd_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset valids", {awvalid, wvalid, arvalid, rsp_valid}, 0);
    chk("reset readies", {bready, rready}, 0);
    chk("reset rsp_timeout", rsp_timeout, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("cmd_ready after reset", cmd_ready, 1);

    // Write with AW and W accepted in the same cycle.
    send_cmd(1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    chk("awvalid", awvalid, 1);
    chk("wvalid", wvalid, 1);
    chk("awaddr", awaddr, 12'h010);
    chk("wdata", wdata, 32'hDEADBEEF);
    chk("wstrb", wstrb, 4'hF);
    awready = 1; wready = 1;
    @(negedge clk);
    awready = 0; wready = 0;
    chk("awvalid dropped", awvalid, 0);
    chk("wvalid dropped", wvalid, 0);
    chk("bready", bready, 1);
    @(negedge clk);
    bvalid = 1; bresp = 2'b00;
    push(32'h0, 2'b00, 1'b0);
    @(negedge clk);
    bvalid = 0;
    chk("bready dropped", bready, 0);
    get_rsp(0);

    // Write with AW accepted three cycles before W.
    aw0 = aw_hs; w0 = w_hs;
    send_cmd(1'b1, 12'h020, 32'hA5A50001, 4'h3);
    awready = 1;
    @(negedge clk);
    awready = 0;
    chk("split awvalid dropped", awvalid, 0);
    chk("split wvalid held", wvalid, 1);
    @(negedge clk);
    @(negedge clk);
    chk("split wvalid still held", wvalid, 1);
    chk("split wdata stable", wdata, 32'hA5A50001);
    chk("split not yet bready", bready, 0);
    wready = 1;
    @(negedge clk);
    wready = 0;
    chk("split wvalid dropped", wvalid, 0);
    chk("split bready", bready, 1);
    bvalid = 1; bresp = 2'b01;
    push(32'h0, 2'b01, 1'b0);
    @(negedge clk);
    bvalid = 0;
    get_rsp(0);
    chk("one AW handshake", aw_hs - aw0, 1);
    chk("one W handshake", w_hs - w0, 1);

    // Stray B/R responses while idle are ignored.
    bvalid = 1; rvalid = 1; rdata = 32'hFFFF0000;
    @(negedge clk);
    bvalid = 0; rvalid = 0;
    @(negedge clk);
    chk("stray idle busy", busy, 0);
    chk("stray idle rsp_valid", rsp_valid, 0);

    // Read, arready after 5 cycles, stray rvalid during RD_REQ, 10-cycle hold.
    send_cmd(1'b0, 12'h0FC, 32'h0, 4'h0);
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, 12'h0FC);
    rvalid = 1; rdata = 32'h00000BAD;
    @(negedge clk);
    rvalid = 0;
    repeat (4) @(negedge clk);
    chk("arvalid held", arvalid, 1);
    chk("rready low in RD_REQ", rready, 0);
    arready = 1;
    @(negedge clk);
    arready = 0;
    chk("arvalid dropped", arvalid, 0);
    chk("rready", rready, 1);
    rvalid = 1; rdata = 32'h12345678; rresp = 2'b00;
    push(32'h12345678, 2'b00, 1'b0);
    @(negedge clk);
    rvalid = 0;
    get_rsp(10);

    // Read with no arready: timeout after 8 cycles.
    send_cmd(1'b0, 12'h044, 32'h0, 4'h0);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (arvalid) hi++;
      @(negedge clk);
    end
    chk("arvalid high cycles", hi, 8);
    chk("arvalid low after timeout", arvalid, 0);
    push(32'h0, 2'b10, 1'b1);
    get_rsp(0);
    chk("rsp_timeout kept in idle", rsp_timeout, 1);

    // arready on the last allowed cycle completes the phase.
    send_cmd(1'b0, 12'h0A0, 32'h0, 4'h0);
    chk("rsp_timeout cleared on accept", rsp_timeout, 0);
    repeat (7) @(negedge clk);
    arready = 1;
    @(negedge clk);
    arready = 0;
    chk("boundary arvalid dropped", arvalid, 0);
    chk("boundary rready", rready, 1);
    chk("boundary no rsp", rsp_valid, 0);
    rvalid = 1; rdata = 32'hCAFE0001; rresp = 2'b11;
    push(32'hCAFE0001, 2'b11, 1'b0);
    @(negedge clk);
    rvalid = 0;
    get_rsp(0);

    // Reset during RD_DATA abandons the read.
    send_cmd(1'b0, 12'h100, 32'h0, 4'h0);
    arready = 1;
    @(negedge clk);
    arready = 0;
    chk("pre-reset rready", rready, 1);
    reset = 1;
    #1;
    chk("async reset rready", rready, 0);
    chk("async reset busy", busy, 0);
    chk("async reset cmd_ready", cmd_ready, 0);
    chk("async reset araddr", araddr, 0);
    chk("async reset rsp_resp", rsp_resp, 0);
    chk("async reset rsp_rdata", rsp_rdata, 0);
    @(negedge clk);
    rvalid = 1; rdata = 32'h55555555;
    reset = 0;
    @(negedge clk);
    rvalid = 0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    chk("no rsp after reset", seen, 0);
    send_cmd(1'b0, 12'h200, 32'h0, 4'h0);
    arready = 1;
    @(negedge clk);
    arready = 0;
    rvalid = 1; rdata = 32'h0BADF00D; rresp = 2'b00;
    push(32'h0BADF00D, 2'b00, 1'b0);
    @(negedge clk);
    rvalid = 0;
    get_rsp(0);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

endmodule
